// File: rtl/spatial_sram_read_scheduler_pkg.sv
// Shared constants and types for the spatial-encoder SRAM read scheduler.
// Modality m (1..3) travels through the read pipeline as 2-bit tag m; tag 0 is unused.
package spatial_sram_read_scheduler_pkg;

    localparam int unsigned HV_DIMENSION = 2000;
    localparam int unsigned ADDR_W       = 8;
    localparam int unsigned NUM_MOD      = 3;

    localparam int unsigned MOD1_BASE_DEF = 0;
    localparam int unsigned MOD2_BASE_DEF = 32;
    localparam int unsigned MOD3_BASE_DEF = 109;
    localparam int unsigned MOD1_CNT_DEF  = 32;
    localparam int unsigned MOD2_CNT_DEF  = 77;
    localparam int unsigned MOD3_CNT_DEF  = 106;

    typedef logic [1:0] mod_tag_t;

    localparam mod_tag_t TagNone = 2'd0;
    localparam mod_tag_t TagMod1 = 2'd1;
    localparam mod_tag_t TagMod2 = 2'd2;
    localparam mod_tag_t TagMod3 = 2'd3;

    typedef struct packed {
        logic [HV_DIMENSION-1:0] im;
        logic [HV_DIMENSION-1:0] neg;
        logic [HV_DIMENSION-1:0] pos;
    } hv_row_t;

endpackage

// File: rtl/spatial_sram_read_scheduler_rr_arbiter3.sv
// 3-way round-robin arbiter: registered pointer, combinational one-hot grant.
// The pointer moves past the granted requester and holds when nothing is granted.
module rr_arbiter3 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] req_i,
    output logic [2:0] gnt_o
);

    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx;
    logic [2:0] sum;
    logic       found;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        idx   = '0;
        sum   = '0;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sum = {1'b0, ptr_q} + 3'(k);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_d      = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spatial_sram_read_scheduler.sv
// Shares one SRAM read port among three modality requesters: maps local channel addresses to
// physical rows, tracks fixed-latency reads in flight and buffers returned rows until acked.
module spatial_sram_read_scheduler
    import spatial_sram_read_scheduler_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MOD1_BASE    = MOD1_BASE_DEF,
    parameter int unsigned MOD2_BASE    = MOD2_BASE_DEF,
    parameter int unsigned MOD3_BASE    = MOD3_BASE_DEF,
    parameter int unsigned MOD1_CNT     = MOD1_CNT_DEF,
    parameter int unsigned MOD2_CNT     = MOD2_CNT_DEF,
    parameter int unsigned MOD3_CNT     = MOD3_CNT_DEF
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic [2:0]              Req_SI,
    input  logic [ADDR_W-1:0]       Addr_mod1_DI,
    input  logic [ADDR_W-1:0]       Addr_mod2_DI,
    input  logic [ADDR_W-1:0]       Addr_mod3_DI,
    output logic [2:0]              Grant_SO,
    output logic [2:0]              ErrAddr_SO,
    input  logic                    SramReady_SI,
    output logic                    SramEn_SO,
    output logic [ADDR_W-1:0]       SramAddr_DO,
    input  logic [HV_DIMENSION-1:0] SramIM_DI,
    input  logic [HV_DIMENSION-1:0] SramNeg_DI,
    input  logic [HV_DIMENSION-1:0] SramPos_DI,
    output logic [2:0]              Valid_SO,
    input  logic [2:0]              Ack_SI,
    output logic [HV_DIMENSION-1:0] IM_mod1_DO,
    output logic [HV_DIMENSION-1:0] Neg_mod1_DO,
    output logic [HV_DIMENSION-1:0] Pos_mod1_DO,
    output logic [HV_DIMENSION-1:0] IM_mod2_DO,
    output logic [HV_DIMENSION-1:0] Neg_mod2_DO,
    output logic [HV_DIMENSION-1:0] Pos_mod2_DO,
    output logic [HV_DIMENSION-1:0] IM_mod3_DO,
    output logic [HV_DIMENSION-1:0] Neg_mod3_DO,
    output logic [HV_DIMENSION-1:0] Pos_mod3_DO
);

    logic [2:0] in_flight_q, in_flight_d;
    logic [2:0] valid_q, valid_d;
    logic [2:0] busy, addr_ok, eligible, grant, ret_onehot;

    logic              sram_en_q, sram_en_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    mod_tag_t          issue_tag_q, issue_tag_d;

    logic [READ_LATENCY-1:0]      pipe_vld_q, pipe_vld_d;
    mod_tag_t [READ_LATENCY-1:0]  pipe_tag_q, pipe_tag_d;

    hv_row_t buf_q [NUM_MOD];
    hv_row_t buf_d [NUM_MOD];

    // Busy looks only at registered state, so an ack never frees a slot in the same cycle.
    assign busy       = in_flight_q | valid_q;
    assign addr_ok[0] = Addr_mod1_DI < ADDR_W'(MOD1_CNT);
    assign addr_ok[1] = Addr_mod2_DI < ADDR_W'(MOD2_CNT);
    assign addr_ok[2] = Addr_mod3_DI < ADDR_W'(MOD3_CNT);
    assign eligible   = Req_SI & ~busy & addr_ok & {3{SramReady_SI}};
    assign ErrAddr_SO = Req_SI & ~busy & ~addr_ok;

    rr_arbiter3 u_arb (
        .clk_i (Clk_CI),
        .rst_i (Reset_RI),
        .req_i (eligible),
        .gnt_o (grant)
    );

    assign Grant_SO = grant;

    always_comb begin
        sram_en_d   = |grant;
        sram_addr_d = sram_addr_q;
        issue_tag_d = TagNone;
        unique case (grant)
            3'b001: begin
                sram_addr_d = ADDR_W'(MOD1_BASE) + Addr_mod1_DI;
                issue_tag_d = TagMod1;
            end
            3'b010: begin
                sram_addr_d = ADDR_W'(MOD2_BASE) + Addr_mod2_DI;
                issue_tag_d = TagMod2;
            end
            3'b100: begin
                sram_addr_d = ADDR_W'(MOD3_BASE) + Addr_mod3_DI;
                issue_tag_d = TagMod3;
            end
            default: ;
        endcase
    end

    // Tag pipeline trails the registered enable; its last stage lines up with valid read data.
    always_comb begin
        pipe_vld_d    = '0;
        pipe_tag_d    = '0;
        pipe_vld_d[0] = sram_en_q;
        pipe_tag_d[0] = issue_tag_q;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
    end

    always_comb begin
        for (int m = 0; m < int'(NUM_MOD); m++) begin
            ret_onehot[m] = pipe_vld_q[READ_LATENCY-1]
                            && (pipe_tag_q[READ_LATENCY-1] == mod_tag_t'(m + 1));
        end
    end

    always_comb begin
        in_flight_d = (in_flight_q | grant) & ~ret_onehot;
        valid_d     = (valid_q & ~Ack_SI) | ret_onehot;
        for (int m = 0; m < int'(NUM_MOD); m++) begin
            buf_d[m] = buf_q[m];
            if (ret_onehot[m]) begin
                buf_d[m] = '{im: SramIM_DI, neg: SramNeg_DI, pos: SramPos_DI};
            end
        end
    end

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            in_flight_q <= '0;
            valid_q     <= '0;
            sram_en_q   <= 1'b0;
            sram_addr_q <= '0;
            issue_tag_q <= TagNone;
            pipe_vld_q  <= '0;
            pipe_tag_q  <= '0;
            for (int m = 0; m < int'(NUM_MOD); m++) begin
                buf_q[m] <= '0;
            end
        end else begin
            in_flight_q <= in_flight_d;
            valid_q     <= valid_d;
            sram_en_q   <= sram_en_d;
            sram_addr_q <= sram_addr_d;
            issue_tag_q <= issue_tag_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_tag_q  <= pipe_tag_d;
            for (int m = 0; m < int'(NUM_MOD); m++) begin
                buf_q[m] <= buf_d[m];
            end
        end
    end

    assign SramEn_SO   = sram_en_q;
    assign SramAddr_DO = sram_addr_q;
    assign Valid_SO    = valid_q;

    assign IM_mod1_DO  = buf_q[0].im;
    assign Neg_mod1_DO = buf_q[0].neg;
    assign Pos_mod1_DO = buf_q[0].pos;
    assign IM_mod2_DO  = buf_q[1].im;
    assign Neg_mod2_DO = buf_q[1].neg;
    assign Pos_mod2_DO = buf_q[1].pos;
    assign IM_mod3_DO  = buf_q[2].im;
    assign Neg_mod3_DO = buf_q[2].neg;
    assign Pos_mod3_DO = buf_q[2].pos;

endmodule

// File: tb/tb_spatial_sram_read_scheduler.sv
// Bench for spatial_sram_read_scheduler: directed scenarios plus random traffic, checked every
// cycle against a timestamp-based model of grants, issued reads and buffered responses.
module tb_spatial_sram_read_scheduler;
    import spatial_sram_read_scheduler_pkg::*;

    localparam int RL = 1;
    localparam int HV = HV_DIMENSION;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        req = '0;
    logic [7:0]        addr [3];
    logic              ready = 1'b0;
    logic [2:0]        ack = '0;
    logic [2:0]        grant, err, valid;
    logic              sram_en;
    logic [7:0]        sram_addr;
    logic [HV-1:0]     sram_im, sram_neg, sram_pos;
    logic [HV-1:0]     im1, neg1, pos1, im2, neg2, pos2, im3, neg3, pos3;
    logic [7:0]        hist [4];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model state: per-modality status and due cycle, expected registered outputs, RR pointer.
    int          cyc;
    bit   [2:0]  m_inflight, m_valid;
    int          m_due [3];
    logic [7:0]  m_row [3];
    int          m_ptr;
    bit          exp_en;
    logic [7:0]  exp_addr;
    logic [2:0]  exp_gnt, exp_err;

    always #5 clk = ~clk;

    spatial_sram_read_scheduler #(.READ_LATENCY(RL)) dut (
        .Clk_CI       (clk),
        .Reset_RI     (rst),
        .Req_SI       (req),
        .Addr_mod1_DI (addr[0]),
        .Addr_mod2_DI (addr[1]),
        .Addr_mod3_DI (addr[2]),
        .Grant_SO     (grant),
        .ErrAddr_SO   (err),
        .SramReady_SI (ready),
        .SramEn_SO    (sram_en),
        .SramAddr_DO  (sram_addr),
        .SramIM_DI    (sram_im),
        .SramNeg_DI   (sram_neg),
        .SramPos_DI   (sram_pos),
        .Valid_SO     (valid),
        .Ack_SI       (ack),
        .IM_mod1_DO   (im1),
        .Neg_mod1_DO  (neg1),
        .Pos_mod1_DO  (pos1),
        .IM_mod2_DO   (im2),
        .Neg_mod2_DO  (neg2),
        .Pos_mod2_DO  (pos2),
        .IM_mod3_DO   (im3),
        .Neg_mod3_DO  (neg3),
        .Pos_mod3_DO  (pos3)
    );

    // Row contents as a function of physical row and field (0 IM, 1 Neg, 2 Pos).
    function automatic logic [HV-1:0] hv(input logic [7:0] row, input int f);
        logic [2047:0] v;
        v = '0;
        for (int i = 0; i < 63; i++) begin
            v[i*32 +: 32] = {row, 8'(f), 16'(i * 7 + 3)} ^ 32'hA5C3_0F1E;
        end
        return v[HV-1:0];
    endfunction

    // SRAM stand-in: data reflects the address that was enabled RL cycles ago.
    always @(posedge clk) begin
        hist[0] <= sram_addr;
        for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
    end
    assign sram_im  = hv(hist[RL-1], 0);
    assign sram_neg = hv(hist[RL-1], 1);
    assign sram_pos = hv(hist[RL-1], 2);

    function automatic int cnt_of(input int m);
        return (m == 0) ? 32 : (m == 1) ? 77 : 106;
    endfunction

    function automatic int base_of(input int m);
        return (m == 0) ? 0 : (m == 1) ? 32 : 109;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic check_hv(input string name, input logic [HV-1:0] got,
                            input logic [HV-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cyc %0d: got ..%08h expected ..%08h", name, cyc,
                     got[31:0], exp[31:0]);
        end
    endtask

    task automatic model_reset();
        cyc        = 0;
        m_inflight = '0;
        m_valid    = '0;
        m_ptr      = 0;
        exp_en     = 1'b0;
        exp_addr   = '0;
        exp_gnt    = '0;
        exp_err    = '0;
    endtask

    task automatic compute_exp();
        exp_gnt = '0;
        exp_err = '0;
        for (int k = 0; k < 3; k++) begin
            int m;
            m = (m_ptr + k) % 3;
            if (exp_gnt == 3'b000 && req[m] && !m_inflight[m] && !m_valid[m]
                && int'(addr[m]) < cnt_of(m) && ready) begin
                exp_gnt[m] = 1'b1;
            end
        end
        for (int m = 0; m < 3; m++) begin
            exp_err[m] = req[m] && !m_inflight[m] && !m_valid[m] && int'(addr[m]) >= cnt_of(m);
        end
    endtask

    task automatic compare();
        check("grant", 32'(grant), 32'(exp_gnt));
        check("err_addr", 32'(err), 32'(exp_err));
        check("valid", 32'(valid), 32'(m_valid));
        check("sram_en", 32'(sram_en), 32'(exp_en));
        if (exp_en) check("sram_addr", 32'(sram_addr), 32'(exp_addr));
        if (m_valid[0]) begin
            check_hv("im1", im1, hv(m_row[0], 0));
            check_hv("neg1", neg1, hv(m_row[0], 1));
            check_hv("pos1", pos1, hv(m_row[0], 2));
        end
        if (m_valid[1]) begin
            check_hv("im2", im2, hv(m_row[1], 0));
            check_hv("neg2", neg2, hv(m_row[1], 1));
            check_hv("pos2", pos2, hv(m_row[1], 2));
        end
        if (m_valid[2]) begin
            check_hv("im3", im3, hv(m_row[2], 0));
            check_hv("neg3", neg3, hv(m_row[2], 1));
            check_hv("pos3", pos3, hv(m_row[2], 2));
        end
    endtask

    task automatic model_update();
        exp_en = (exp_gnt != 3'b000);
        for (int m = 0; m < 3; m++) begin
            if (exp_gnt[m]) begin
                exp_addr      = 8'(base_of(m) + int'(addr[m]));
                m_inflight[m] = 1'b1;
                m_due[m]      = cyc + 2 + RL;
                m_row[m]      = exp_addr;
                m_ptr         = (m + 1) % 3;
            end
        end
        cyc++;
        for (int m = 0; m < 3; m++) begin
            if (m_valid[m] && ack[m]) m_valid[m] = 1'b0;
            if (m_inflight[m] && cyc == m_due[m]) begin
                m_inflight[m] = 1'b0;
                m_valid[m]    = 1'b1;
            end
        end
    endtask

    // Called right after inputs change at the falling edge.
    task automatic settle();
        #1;
        compute_exp();
        compare();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [2:0] a);
        req = '0;
        ack = a;
        for (int i = 0; i < n; i++) begin
            settle();
            advance();
        end
        ack = '0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic [2:0] order [$];
    logic [2:0] pv, last_gnt, last_err;

    initial begin
        for (int m = 0; m < 3; m++) addr[m] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Reset state
        settle();
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_en", 32'(sram_en), 32'h0);
        check("rst_addr", 32'(sram_addr), 32'h0);
        advance();

        // 1: single read of mod1 channel 5
        ready = 1'b1; req = 3'b001; addr[0] = 8'd5;
        settle(); check("t1_grant", 32'(grant), 32'h1); advance();
        req = '0;
        settle(); check("t1_en", 32'(sram_en), 32'h1); check("t1_addr", 32'(sram_addr), 32'd5);
        advance();
        settle(); check("t1_valid_early", 32'(valid), 32'h0); advance();
        settle(); check("t1_valid", 32'(valid), 32'h1); check_hv("t1_im", im1, hv(8'd5, 0));
        check_hv("t1_pos", pos1, hv(8'd5, 2)); advance();
        settle(); check("t1_hold", 32'(valid), 32'h1); advance();
        ack = 3'b001; settle(); advance();
        ack = '0; settle(); check("t1_cleared", 32'(valid), 32'h0); advance();

        // 2: all three requesting, ack the cycle after each valid
        reset_dut();
        req = 3'b111; addr[0] = 0; addr[1] = 0; addr[2] = 0; pv = '0;
        for (int i = 0; i < 24; i++) begin
            ack = pv & m_valid;
            settle();
            if (grant != 3'b000) order.push_back(grant);
            pv = m_valid;
            advance();
        end
        check("t2_order0", (order.size() > 0) ? 32'(order[0]) : 32'hx, 32'h1);
        check("t2_order1", (order.size() > 1) ? 32'(order[1]) : 32'hx, 32'h2);
        check("t2_order2", (order.size() > 2) ? 32'(order[2]) : 32'hx, 32'h4);
        check("t2_order3", (order.size() > 3) ? 32'(order[3]) : 32'hx, 32'h1);
        idle(6, 3'b111);

        // 3: out-of-range then last valid channel of mod3
        req = 3'b100; addr[2] = 8'd106;
        for (int i = 0; i < 3; i++) begin
            settle(); check("t3_err", 32'(err), 32'h4); check("t3_noen", 32'(sram_en), 32'h0);
            advance();
        end
        addr[2] = 8'd105;
        settle(); check("t3_grant", 32'(grant), 32'h4); advance();
        req = '0;
        settle(); check("t3_addr", 32'(sram_addr), 32'd214); advance();
        idle(6, 3'b111);

        // 4: held response blocks the same modality until acked
        req = 3'b001; addr[0] = 8'd3;
        for (int i = 0; i < 13; i++) begin
            settle(); advance();
        end
        ack = 3'b001; settle(); advance();
        ack = '0;
        settle(); check("t4_valid", 32'(valid), 32'h0); check("t4_regrant", 32'(grant), 32'h1);
        advance();
        idle(6, 3'b111);

        // 5: SRAM not ready
        req = 3'b010; addr[1] = 8'd10; ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle(); check("t5_nogrant", 32'(grant), 32'h0); advance();
        end
        ready = 1'b1;
        settle(); check("t5_grant", 32'(grant), 32'h2); advance();
        idle(6, 3'b111);

        // 6: asynchronous reset with a read just issued
        req = 3'b001; addr[0] = 8'd2;
        settle(); advance();
        req = '0;
        settle();
        #2 rst = 1'b1;
        #1;
        check("t6_valid", 32'(valid), 32'h0);
        check("t6_en", 32'(sram_en), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(5, 3'b000);
        req = 3'b111; addr[0] = 0; addr[1] = 0; addr[2] = 0;
        settle(); check("t6_ptr", 32'(grant), 32'h1); advance();
        idle(6, 3'b111);

        // Random traffic
        last_gnt = '0; last_err = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int m = 0; m < 3; m++) begin
                if (req[m] && (last_gnt[m] || (last_err[m] && $urandom_range(0, 1) == 1))) begin
                    req[m] = 1'b0;
                end else if (!req[m] && $urandom_range(0, 2) == 0) begin
                    req[m] = 1'b1;
                    if ($urandom_range(0, 7) == 0)
                        addr[m] = 8'(cnt_of(m) + int'($urandom_range(0, 3)));
                    else
                        addr[m] = 8'($urandom_range(0, cnt_of(m) - 1));
                end
            end
            ack   = 3'($urandom_range(0, 7));
            ready = ($urandom_range(0, 4) != 0);
            settle();
            last_gnt = exp_gnt;
            last_err = exp_err;
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
